// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes and sequencer states shared by the memory stage.
package mem_stage_pkg;
    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] LB     = 6'h20;
    localparam logic [5:0] LH     = 6'h21;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] LBU    = 6'h24;
    localparam logic [5:0] LHU    = 6'h25;
    localparam logic [5:0] SB     = 6'h28;
    localparam logic [5:0] SH     = 6'h29;
    localparam logic [5:0] SW     = 6'h2B;
    typedef enum logic {CLEAR, RUN} state_e;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-organised data RAM, combinational read, byte-enabled synchronous write.
module dmem_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [DEPTH];
    assign rdata_o = mem_q[raddr_i];
    always_ff @(posedge clk_i)
        for (int b = 0; b < 4; b++)
            if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with big-endian sub-word loads/stores
// and a post-reset sequencer that zeroes the data RAM one word per cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic [31:0] Wdata,
    output logic        Busy,
    output logic        Misalign,
    output logic        OutRange
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [5:0]        op;
    logic [1:0]        off;
    logic [ADDR_W-1:0] widx;
    logic              is_ld, is_st, is_half, is_word, sgn, fault, do_st, clearing;
    logic [3:0]        st_be, be;
    logic [31:0]       st_data, rdata, sh, ld_val;
    logic              unused_ins;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign unused_ins = ^Ins[25:0];
    assign op       = Ins[31:26];
    assign off      = Result[1:0];
    assign widx     = Result[ADDR_W+1:2];
    assign Busy     = RST | (state_q == CLEAR);
    assign clearing = ~RST & (state_q == CLEAR);
    assign is_ld    = op inside {LB, LBU, LH, LHU, LW};
    assign is_st    = op inside {SB, SH, SW};
    assign is_half  = op inside {LH, LHU, SH};
    assign is_word  = op inside {LW, SW};
    assign sgn      = op inside {LB, LH};

    assign Misalign = ~Busy & (is_ld | is_st) & ((is_half & off[0]) | (is_word & |off));
    assign OutRange = ~Busy & (is_ld | is_st) & |Result[31:ADDR_W+2];
    assign fault    = Misalign | OutRange;
    assign do_st    = is_st & ~Busy & ~fault;

    // Offset 0 is the most significant lane, so be[3] covers byte address 0.
    assign st_be   = is_word ? 4'hF : is_half ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> off;
    assign st_data = is_word ? Rdata2 : is_half ? {2{Rdata2[15:0]}} : {4{Rdata2[7:0]}};
    assign be      = clearing ? 4'hF : do_st ? st_be : 4'h0;

    dmem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk_i   (CLK),
        .be_i    (be),
        .waddr_i (clearing ? clr_idx_q : widx),
        .wdata_i (clearing ? 32'h0 : st_data),
        .raddr_i (widx),
        .rdata_o (rdata)
    );

    // Shift the addressed lane up to the top so extraction is offset-independent.
    assign sh     = rdata << {off, 3'b000};
    assign ld_val = is_word ? rdata
                  : is_half ? {{16{sgn & sh[31]}}, sh[31:16]}
                  : {{24{sgn & sh[31]}}, sh[31:24]};
    assign Wdata  = (Busy | fault) ? 32'h0 : is_ld ? ld_val : Result;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
module tb_mem_stage;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam logic [5:0] OP_ADD = 6'h00, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    typedef struct {
        logic [34:0] v;
        string       tag;
    } exp_t;

    logic        CLK = 0, RST = 1;
    logic [31:0] Ins = 0, Result = 0, Rdata2 = 0;
    logic [31:0] Wdata;
    logic        Busy, Misalign, OutRange;
    exp_t        sb[$];
    int          checks = 0, errors = 0;

    mem_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .Wdata(Wdata), .Busy(Busy), .Misalign(Misalign), .OutRange(OutRange)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic rst, input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                        input logic [31:0] ew, input logic eb, input logic em, input logic eo, input string tag);
        exp_t e;
        exp_t got_e;
        logic [34:0] got;
        RST = rst; Ins = {op, 26'h0}; Result = res; Rdata2 = rd2;
        e.v = {eb, em, eo, ew}; e.tag = tag;
        sb.push_back(e);
        @(negedge CLK);
        got_e = sb.pop_front();
        got = {Busy, Misalign, OutRange, Wdata};
        checks++;
        assert (got === got_e.v) else begin
            errors++;
            $error("FAIL %s: busy/mis/oor/wdata got %h expected %h", got_e.tag, got, got_e.v);
        end
        @(posedge CLK); #1;
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        RST = 0; Ins = {OP_ADD, 26'h0}; Result = 0;
        while (n < 2 * DEPTH) begin
            @(negedge CLK);
            if (!Busy) break;
            n++;
        end
        checks++;
        assert (n == DEPTH) else begin
            errors++;
            $error("FAIL %s: busy cycles got %0d expected %0d", tag, n, DEPTH);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        #1;
        step(1, OP_LW, 32'h0, 32'h0, 32'h0, 1, 0, 0, "reset_busy");
        wait_clear("clear_len");
        for (int a = 0; a < 4; a++)
            step(0, OP_LW, a * 32'h154, 32'h0, 32'h0, 0, 0, 0, "cleared_lw");
        step(0, OP_LW, 32'h3FC, 32'h0, 32'h0, 0, 0, 0, "cleared_top");

        step(0, OP_SW, 32'h10, 32'h8899AABB, 32'h10, 0, 0, 0, "sw_pass");
        step(0, OP_LB, 32'h10, 32'h0, 32'hFFFFFF88, 0, 0, 0, "lb_sext");
        step(0, OP_LBU, 32'h13, 32'h0, 32'h000000BB, 0, 0, 0, "lbu");
        step(0, OP_LH, 32'h12, 32'h0, 32'hFFFFAABB, 0, 0, 0, "lh_sext");
        step(0, OP_LW, 32'h10, 32'h0, 32'h8899AABB, 0, 0, 0, "lw");

        step(0, OP_SB, 32'h11, 32'h00000012, 32'h11, 0, 0, 0, "sb");
        step(0, OP_LW, 32'h10, 32'h0, 32'h8812AABB, 0, 0, 0, "lw_after_sb");
        step(0, OP_LB, 32'h11, 32'h0, 32'h00000012, 0, 0, 0, "lb_pos");
        step(0, OP_SH, 32'h12, 32'h00003456, 32'h12, 0, 0, 0, "sh");
        step(0, OP_LW, 32'h10, 32'h0, 32'h88123456, 0, 0, 0, "lw_after_sh");
        step(0, OP_LHU, 32'h10, 32'h0, 32'h00008812, 0, 0, 0, "lhu");
        step(0, OP_LH, 32'h10, 32'h0, 32'hFFFF8812, 0, 0, 0, "lh_hi");

        step(0, OP_LW, 32'h06, 32'h0, 32'h0, 0, 1, 0, "lw_mis");
        step(0, OP_LH, 32'h13, 32'h0, 32'h0, 0, 1, 0, "lh_mis");
        step(0, OP_SW, 32'h05, 32'hDEADBEEF, 32'h0, 0, 1, 0, "sw_mis");
        step(0, OP_LW, 32'h04, 32'h0, 32'h0, 0, 0, 0, "no_mis_write");
        step(0, OP_SW, DEPTH * 4, 32'hCAFEF00D, 32'h0, 0, 0, 1, "sw_oor");
        step(0, OP_LW, 32'h0, 32'h0, 32'h0, 0, 0, 0, "no_wrap_write");
        step(0, OP_LW, DEPTH * 4 + 1, 32'h0, 32'h0, 0, 1, 1, "both_flags");

        step(0, OP_ADD, 32'h1234, 32'hFFFFFFFF, 32'h1234, 0, 0, 0, "add_pass");
        step(0, OP_ADD, DEPTH * 4 + 3, 32'h0, DEPTH * 4 + 3, 0, 0, 0, "add_no_flags");
        step(0, OP_LW, 32'h10, 32'h0, 32'h88123456, 0, 0, 0, "add_no_write");

        step(1, OP_ADD, 32'h55, 32'h0, 32'h0, 1, 0, 0, "rst_busy");
        step(0, OP_SW, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 0, 0, "sw_busy");
        for (int i = 1; i < DEPTH / 2; i++)
            step(0, OP_LW, 32'h7, 32'h0, 32'h0, 1, 0, 0, "clear_busy");
        step(1, OP_ADD, 32'h0, 32'h0, 32'h0, 1, 0, 0, "mid_rst");
        wait_clear("restart_len");
        step(0, OP_LW, 32'h0, 32'h0, 32'h0, 0, 0, 0, "busy_sw_ignored");
        step(0, OP_LW, 32'h10, 32'h0, 32'h0, 0, 0, 0, "recleared");
        step(0, OP_LW, 32'h3FC, 32'h0, 32'h0, 0, 0, 0, "recleared_top");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
